wb_ddr_bridge: RTL

Parametrised Wishbone classic slave to Avalon-style local-interface master, placed in front of the DDR/SDRAM controller core. Single clock domain, replacing the two-clock handshake arrangement. Adds configurable data width and memory size, a posted-write FIFO, read-after-write ordering, a read timeout with error response, and per-byte enables on both reads and writes.

---
 rtl/wb_ddr_bridge.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/wb_ddr_bridge.sv
// Wishbone classic slave to local-interface master for the DDR/SDRAM controller.
// Posted-write FIFO, read-after-write ordering, range check and read timeout.
module wb_ddr_bridge #(
   parameter int DW          = 32,
   parameter int MEM_LOG2    = 25,
   parameter int CHK_HI      = 27,
   parameter int WFIFO_DEPTH = 4,
   parameter int RD_TIMEOUT  = 255
) (
   input  logic                                  wb_clk_i,
   input  logic                                  wb_rst_n_i,
   input  logic [31:0]                           wb_adr_i,
   input  logic [DW-1:0]                         wb_dat_i,
   input  logic [DW/8-1:0]                       wb_sel_i,
   input  logic                                  wb_we_i,
   input  logic                                  wb_cyc_i,
   input  logic                                  wb_stb_i,
   output logic [DW-1:0]                         wb_dat_o,
   output logic                                  wb_ack_o,
   output logic                                  wb_err_o,
   output logic [MEM_LOG2-$clog2(DW/8)-1:0]      local_address,
   output logic                                  local_read_req,
   output logic                                  local_write_req,
   output logic                                  local_burstbegin,
   output logic [DW-1:0]                         local_wdata,
   output logic [DW/8-1:0]                       local_be,
   output logic [1:0]                            local_size,
   input  logic                                  local_ready,
   input  logic [DW-1:0]                         local_rdata,
   input  logic                                  local_rdata_valid,
   input  logic                                  local_init_done,
   output logic [$clog2(WFIFO_DEPTH):0]          wfifo_level_o,
   output logic                                  rd_timeout_o
);

   localparam int BE  = DW / 8;
   localparam int BL  = $clog2(BE);
   localparam int LAW = MEM_LOG2 - BL;
   localparam int PW  = $clog2(WFIFO_DEPTH);
   localparam int LW  = PW + 1;
   localparam int TW  = (RD_TIMEOUT > 0) ? $clog2(RD_TIMEOUT + 1) : 1;

   typedef enum logic [2:0] {
      IDLE, WR_ACK, RD_DRAIN, RD_REQ, RD_WAIT, RD_ACK, ERR
   } state_t;

   state_t         state;
   logic [LAW-1:0] fifo_adr [WFIFO_DEPTH];
   logic [DW-1:0]  fifo_dat [WFIFO_DEPTH];
   logic [BE-1:0]  fifo_sel [WFIFO_DEPTH];
   logic [PW-1:0]  wr_ptr, rd_ptr;
   logic [LW-1:0]  level;
   logic [LAW-1:0] rd_adr;
   logic [BE-1:0]  rd_sel;
   logic [TW-1:0]  to_cnt;

   logic req, in_range, fifo_full, fifo_empty, push, pop, rd_active, wr_issue;
   logic unused_adr;

   assign req        = wb_cyc_i & wb_stb_i;
   assign in_range   = ~|wb_adr_i[CHK_HI:MEM_LOG2];
   assign fifo_full  = (level == LW'(WFIFO_DEPTH));
   assign fifo_empty = (level == '0);
   assign push       = (state == IDLE) & local_init_done & req & in_range & wb_we_i & ~fifo_full;
   assign rd_active  = (state == RD_REQ) | (state == RD_WAIT);
   assign wr_issue   = ~fifo_empty & ~rd_active;
   assign pop        = wr_issue & local_ready;
   // Region-select bits above CHK_HI and the byte offset are deliberately ignored.
   assign unused_adr = ^{wb_adr_i[31:CHK_HI+1], wb_adr_i[BL-1:0]};

   assign local_size       = 2'b01;
   assign local_burstbegin = local_read_req | local_write_req;
   assign wfifo_level_o    = level;

   // Outputs decode registered state only, so a read never overlaps a write.
   always_comb begin
      local_read_req  = 1'b0;
      local_write_req = 1'b0;
      local_address   = '0;
      local_wdata     = '0;
      local_be        = '0;
      if (state == RD_REQ) begin
         local_read_req = 1'b1;
         local_address  = rd_adr;
         local_be       = rd_sel;
      end else if (wr_issue) begin
         local_write_req = 1'b1;
         local_address   = fifo_adr[rd_ptr];
         local_wdata     = fifo_dat[rd_ptr];
         local_be        = fifo_sel[rd_ptr];
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (push) begin
         fifo_adr[wr_ptr] <= wb_adr_i[MEM_LOG2-1:BL];
         fifo_dat[wr_ptr] <= wb_dat_i;
         fifo_sel[wr_ptr] <= wb_sel_i;
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         if (push && !pop)      level <= level + LW'(1);
         else if (pop && !push) level <= level - LW'(1);
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         state        <= IDLE;
         wb_ack_o     <= 1'b0;
         wb_err_o     <= 1'b0;
         wb_dat_o     <= '0;
         rd_timeout_o <= 1'b0;
         to_cnt       <= '0;
         rd_adr       <= '0;
         rd_sel       <= '0;
      end else begin
         wb_ack_o <= 1'b0;
         wb_err_o <= 1'b0;
         case (state)
            IDLE: begin
               if (local_init_done && req) begin
                  if (!in_range) begin
                     state    <= ERR;
                     wb_err_o <= 1'b1;
                  end else if (!wb_we_i) begin
                     state  <= RD_DRAIN;
                     rd_adr <= wb_adr_i[MEM_LOG2-1:BL];
                     rd_sel <= wb_sel_i;
                  end else if (!fifo_full) begin
                     state    <= WR_ACK;
                     wb_ack_o <= 1'b1;
                  end
               end
            end
            WR_ACK, RD_ACK, ERR: state <= IDLE;
            RD_DRAIN: begin
               if (fifo_empty) state <= RD_REQ;
            end
            RD_REQ: begin
               if (local_ready) begin
                  state  <= RD_WAIT;
                  to_cnt <= '0;
               end
            end
            RD_WAIT: begin
               if (local_rdata_valid) begin
                  state    <= RD_ACK;
                  wb_ack_o <= 1'b1;
                  wb_dat_o <= local_rdata;
               end else if (RD_TIMEOUT != 0 && to_cnt == TW'(RD_TIMEOUT)) begin
                  state        <= ERR;
                  wb_err_o     <= 1'b1;
                  rd_timeout_o <= 1'b1;
               end else begin
                  to_cnt <= to_cnt + TW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
